regfile_stack_ctrl: RTL
=======================

# regfile_stack_ctrl

Sequencer for the stacked register file. It turns interrupt-entry and interrupt-return events from the core into single-cycle push/pop commands on the register file's command input. It also keeps a matching stack of preempted priority levels, so nesting depth and the current running priority are always known. It sits between the interrupt controller / mret decode and the stacked register file instance.

## Interface
- DEPTH, 4, maximum nesting levels (number of context pushes the register file can hold)
- PRIO_W, 3, width of an interrupt priority; priority 0 is the base (thread) level
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enter_valid  in  1  interrupt entry request
- i_enter_prio  in  PRIO_W  priority of requesting interrupt, stable while i_enter_valid high
- o_enter_ready  out  1  entry accepted this cycle when high together with i_enter_valid
- i_exit_valid  in  1  interrupt return request (mret)
- o_exit_ready  out  1  return accepted this cycle when high together with i_exit_valid
- o_command  out  2  RegFilePkg Command to the register file (Command_none / Command_push / Command_pop)
- o_depth  out  $clog2(DEPTH+1)  current nesting depth
- o_cur_prio  out  PRIO_W  priority of the running context
- o_busy  out  1  high while a command is being issued
- o_overflow  out  1  sticky: entry attempted at full depth
- o_underflow  out  1  sticky: return attempted at depth 0
- i_err_clear  in  1  synchronous clear of both sticky flags

## Operation
- FSM states: IDLE, PUSH, POP.
- Entry is acceptable when the FSM is in IDLE, i_enter_prio > o_cur_prio, and o_depth < DEPTH.
- o_enter_ready = entry acceptable. It is combinational and may depend on i_enter_prio but not on i_enter_valid.
- Return is acceptable when the FSM is in IDLE, o_depth > 0, and no acceptable entry is being presented. Entry wins a same-cycle collision, which nests the new interrupt before the return.
- o_exit_ready = return acceptable.
- Entry accept edge:
  - o_cur_prio is pushed onto the internal priority stack at index o_depth.
  - o_cur_prio <= i_enter_prio; o_depth += 1; FSM -> PUSH.
- Return accept edge:
  - o_cur_prio <= priority stack[o_depth-1]; o_depth -= 1; FSM -> POP.
- PUSH: o_command = Command_push for exactly that cycle, then FSM -> IDLE.
- POP: o_command = Command_pop for exactly that cycle, then FSM -> IDLE.
- IDLE: o_command = Command_none.
- o_busy = (state != IDLE). Both ready outputs are low while busy.
- Entry with i_enter_prio <= o_cur_prio: held off (ready low), no error, nothing changes.
- Overflow: when IDLE, i_enter_valid, i_enter_prio > o_cur_prio, and o_depth == DEPTH, o_overflow is set at the next edge. The request is not accepted and no command is issued.
- Underflow: when IDLE, i_exit_valid, and o_depth == 0, o_underflow is set at the next edge. No command is issued.
- i_err_clear clears both flags at the edge. A set condition in the same cycle wins over the clear.
- Counter and stack never wrap: o_depth stays within 0..DEPTH by construction.

## Timing
- Reset (i_reset low, asynchronous) forces:
  - FSM = IDLE, o_command = Command_none, o_depth = 0, o_cur_prio = 0
  - o_busy = 0, o_overflow = 0, o_underflow = 0
  - priority stack contents: don't-care
- Reset asserted while in PUSH/POP: o_command drops to Command_none immediately, with no completion of the pending push/pop.
- Latency: the command appears on o_command in the cycle immediately after the accept edge and lasts 1 cycle.
- o_depth and o_cur_prio update on the accept edge, one cycle before the register file sees the command.
- Throughput: at most one accepted event per 2 cycles (accept, command). The next accept is possible in the cycle after the command.
- All outputs except o_enter_ready and o_exit_ready are registered.

## Test plan
- Reset then idle: i_reset low 2 cycles, then high -> o_command none, o_depth 0, o_cur_prio 0, flags 0, both ready as specified.
- Single entry/return: enter prio 3 -> next cycle o_command push for 1 cycle, o_depth 1, o_cur_prio 3. Then exit -> o_command pop for 1 cycle, o_depth 0, o_cur_prio 0.
- Nesting and masking: enter prio 2, then prio 2 again, which is held (ready 0, no command). Then prio 5 is accepted -> o_depth 2, o_cur_prio 5. Two exits restore o_cur_prio 2 then 0.
- Overflow and underflow: with DEPTH=4, accept prios 1,2,3,4, then request prio 6 -> no command, o_overflow 1, o_depth stays 4. Drain 4 exits, then exit again -> o_underflow 1. i_err_clear -> both flags 0.
- Collision: at depth 1, cur prio 2, assert enter prio 4 and exit in the same cycle -> entry accepted, exit ready 0, push issued, o_depth 2. Exit accepted 2 cycles later.
- Reset mid-operation: assert i_reset during the PUSH cycle -> o_command none immediately, o_depth 0, o_cur_prio 0 after release.

Source files
------------

// File: rtl/regfile_stack_ctrl_if.sv
// Event handshake and command bus between the interrupt controller / mret decode
// and the stacked register file sequencer.
interface regfile_stack_ctrl_if #(
  parameter int unsigned PRIO_W = 3
);
  logic              i_enter_valid;
  logic [PRIO_W-1:0] i_enter_prio;
  logic              o_enter_ready;
  logic              i_exit_valid;
  logic              o_exit_ready;
  logic [1:0]        o_command;

  modport master (
    output i_enter_valid, i_enter_prio, i_exit_valid,
    input  o_enter_ready, o_exit_ready, o_command
  );

  modport slave (
    input  i_enter_valid, i_enter_prio, i_exit_valid,
    output o_enter_ready, o_exit_ready, o_command
  );
endinterface

// File: rtl/regfile_stack_ctrl.sv
// Turns interrupt entry/return events into single-cycle push/pop commands for the
// stacked register file, tracking nesting depth and preempted priority levels.
module regfile_stack_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PRIO_W = 3,
  localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  regfile_stack_ctrl_if.slave bus,
  output logic [DW-1:0]     o_depth,
  output logic [PRIO_W-1:0] o_cur_prio,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_err_clear
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_PUSH = 2'd1;
  localparam logic [1:0] CMD_POP  = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PUSH = 2'd1;
  localparam logic [1:0] S_POP  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_command;
  logic [DW-1:0]     r_depth;
  logic [PRIO_W-1:0] r_cur_prio;
  logic              r_busy;
  logic              r_overflow;
  logic              r_underflow;
  logic [PRIO_W-1:0] r_stack [DEPTH];

  logic              w_idle;
  logic              w_prio_higher;
  logic              w_enter_ok;
  logic              w_enter_take;
  logic              w_exit_ok;
  logic              w_exit_take;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;

  always_comb begin
    w_idle        = (r_state == S_IDLE);
    w_prio_higher = (bus.i_enter_prio > r_cur_prio);
    w_enter_ok    = w_idle && w_prio_higher && (r_depth < DEPTH_V);
    w_enter_take  = w_enter_ok && bus.i_enter_valid;
    // Entry wins a same-cycle collision; the return waits until after the push.
    w_exit_ok     = w_idle && (r_depth != '0) && !w_enter_take;
    w_exit_take   = w_exit_ok && bus.i_exit_valid;
    w_ovf_set     = w_idle && bus.i_enter_valid && w_prio_higher && (r_depth == DEPTH_V);
    w_unf_set     = w_idle && bus.i_exit_valid && (r_depth == '0);
    w_push_idx    = IDX_W'(r_depth);
    w_pop_idx     = IDX_W'(r_depth - DW'(1));
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_command  <= CMD_NONE;
      r_depth    <= '0;
      r_cur_prio <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_enter_take) begin
            r_state    <= S_PUSH;
            r_command  <= CMD_PUSH;
            r_busy     <= 1'b1;
            r_cur_prio <= bus.i_enter_prio;
            r_depth    <= r_depth + DW'(1);
          end else if (w_exit_take) begin
            r_state    <= S_POP;
            r_command  <= CMD_POP;
            r_busy     <= 1'b1;
            r_cur_prio <= r_stack[w_pop_idx];
            r_depth    <= r_depth - DW'(1);
          end
        end
        S_PUSH, S_POP: begin
          r_state   <= S_IDLE;
          r_command <= CMD_NONE;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_command <= CMD_NONE;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Stack contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge i_clk) begin
    if (w_enter_take) begin
      r_stack[w_push_idx] <= r_cur_prio;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (i_err_clear) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (i_err_clear) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.o_enter_ready = w_enter_ok;
  assign bus.o_exit_ready  = w_exit_ok;
  assign bus.o_command     = r_command;
  assign o_depth           = r_depth;
  assign o_cur_prio        = r_cur_prio;
  assign o_busy            = r_busy;
  assign o_overflow        = r_overflow;
  assign o_underflow       = r_underflow;

endmodule
